chip8_regfile_bank: RTL and testbench
=====================================

CHIP8_REGFILE_BANK -- requirements
Module: chip8_regfile_bank

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits.
REQ-002 Parameter NREG, default 16, number of V registers (V0..VF).
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-004 cpu_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 reg_addr1, reg_addr2  in  4  read/write addresses, ports 1 and 2.
REQ-007 reg_writedata1, reg_writedata2  in  8  write data, ports 1 and 2.
REQ-008 reg_WE1, reg_WE2  in  1  write enables, ports 1 and 2.
REQ-009 reg_VFwritedata  in  8; reg_WEVF  in  1  dedicated flag-register write.
REQ-010 reg_readdata1, reg_readdata2, reg_VFreaddata  out  8  read data for addr1, addr2, VF.
REQ-011 bulk_start  in  1  one-cycle request to run a block transfer (FX55/FX65).
REQ-012 bulk_dir  in  1  0 = store V0..Vx to memory, 1 = load V0..Vx from memory.
REQ-013 bulk_last  in  4  x, the highest register index transferred.
REQ-014 bulk_busy  out  1  transfer in progress; bulk_done  out  1  one-cycle completion pulse.
REQ-015 mem_req  out  1; mem_we  out  1; mem_off  out  4 (offset from I); mem_wdata  out  8.
REQ-016 mem_ack  in  1  accepts current beat; mem_rdata  in  8  load data, valid with mem_ack.

Function
REQ-017 Read ports SHALL be combinational from stored state; a write becomes visible the cycle after its edge (no write-through bypass).
REQ-018 Writes SHALL occur at the rising edge when the enable is high and bulk_busy is low.
REQ-019 Same-address conflict: port 1 SHALL override port 2.
REQ-020 Address F with reg_WEVF also high: VF port SHALL override ports 1 and 2.
REQ-021 While bulk_busy is high, reg_WE1/reg_WE2/reg_WEVF SHALL be ignored; reads stay live.
REQ-022 FSM states: IDLE, XFER, DONE; reset state IDLE.
REQ-023 IDLE -> XFER on bulk_start: latch bulk_dir and bulk_last, set index i=0; bulk_busy high from the next cycle.
REQ-024 In XFER, mem_req SHALL be high, mem_off=i, mem_we=~dir, mem_wdata=V[i] (store), all held stable until mem_ack.
REQ-025 On mem_ack in XFER: load stores mem_rdata into V[i]; if i==last go to DONE, else i=i+1 and mem_req stays high.
REQ-026 DONE SHALL last exactly one cycle with bulk_done=1, mem_req=0, bulk_busy=1, then return to IDLE.
REQ-027 bulk_last=0 SHALL transfer exactly one beat (V0); bulk_last=F SHALL transfer 16 beats, the last writing VF.
REQ-028 bulk_start while not IDLE SHALL be ignored.
REQ-029 mem_ack outside XFER SHALL be ignored.
REQ-030 Index i SHALL never wrap past bulk_last.

Reset
REQ-031 reset_n low SHALL immediately clear V0..VF, i, and latched bulk fields to 0, and force IDLE.
REQ-032 During reset, mem_req, mem_we, bulk_busy and bulk_done SHALL be 0; mem_off and mem_wdata SHALL be 0.
REQ-033 Reset mid-transfer SHALL abort it with no done pulse; registers already loaded are cleared.

Structure
REQ-034 Package chip8_pkg SHALL hold bulk_state_t (IDLE/XFER/DONE), VF_IDX=4'hF, and byte/nibble typedefs.
REQ-035 The FSM and index counter SHALL be one sub-module, chip8_bulk_seq; the storage array stays in the top.

Verification
REQ-036 Write V3=0x2A via port 1 -> reg_readdata2 at addr 3 reads 0x2A the next cycle, old value during the write cycle.
REQ-037 WE1 addr 5 data 0x11, WE2 addr 5 data 0x22 together -> V5=0x11; WE1 addr F 0x01 with WEVF 0x80 -> VF=0x80.
REQ-038 Store with last=2, V0..V2=0x10,0x20,0x30, ack every other cycle -> beats off 0,1,2 data 0x10,0x20,0x30, then one bulk_done pulse.
REQ-039 Load with last=F, mem_rdata=0xF0+off, ack every cycle -> V0..VF=0xF0..0xFF, 16 beats, then bulk_done; CPU writes during busy have no effect.
REQ-040 Reset asserted on beat 2 of load with last=7 -> mem_req drops at once, no bulk_done, all V=0, FSM IDLE.
REQ-041 bulk_start during busy, and mem_ack in IDLE -> no state change and no extra beats.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 V-register bank and its
// FX55/FX65 block-transfer sequencer.
package chip8_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } bulk_state_t;

  localparam nibble_t VF_IDX = 4'hF;

  // Advance the transfer index, holding at the last register so it never wraps.
  function automatic nibble_t next_idx(input nibble_t i, input nibble_t last);
    if (i == last) begin
      return last;
    end else begin
      return i + 4'd1;
    end
  endfunction

endpackage

// File: rtl/chip8_bulk_seq.sv
// Block-transfer sequencer: walks V0..Vx one memory beat at a time,
// handshaking on mem_ack, and pulses done once the last beat is accepted.
module chip8_bulk_seq
  import chip8_pkg::*;
(
  input  logic    cpu_clk,
  input  logic    reset_n,
  input  logic    i_start,
  input  logic    i_dir,
  input  nibble_t i_last,
  input  logic    i_ack,
  output logic    o_busy,
  output logic    o_done,
  output logic    o_req,
  output logic    o_we,
  output nibble_t o_idx,
  output logic    o_load_we
);

  bulk_state_t r_state;
  nibble_t     r_idx;
  nibble_t     r_last;
  logic        r_dir;
  logic        r_busy;
  logic        r_done;
  logic        r_req;
  logic        r_we;

  // Transfer FSM with registered handshake outputs.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
      r_last  <= 4'd0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= XFER;
            r_dir   <= i_dir;
            r_last  <= i_last;
            r_idx   <= 4'd0;
            r_busy  <= 1'b1;
            r_req   <= 1'b1;
            r_we    <= ~i_dir;
          end
        end
        XFER: begin
          if (i_ack) begin
            if (r_idx == r_last) begin
              r_state <= DONE;
              r_req   <= 1'b0;
              r_we    <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= next_idx(r_idx, r_last);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_req     = r_req;
  assign o_we      = r_we;
  assign o_idx     = r_idx;
  // r_req is only set in XFER, so this strobe cannot fire outside a load beat.
  assign o_load_we = r_req & r_dir & i_ack;

endmodule

// File: rtl/chip8_regfile_bank.sv
// CHIP-8 V0..VF register file with two CPU read/write ports, a dedicated
// VF flag port, and a sequenced bulk store/load path to memory.
module chip8_regfile_bank
  import chip8_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 16
) (
  input  logic              cpu_clk,
  input  logic              reset_n,
  input  nibble_t           reg_addr1,
  input  nibble_t           reg_addr2,
  input  logic [DATA_W-1:0] reg_writedata1,
  input  logic [DATA_W-1:0] reg_writedata2,
  input  logic              reg_WE1,
  input  logic              reg_WE2,
  input  logic [DATA_W-1:0] reg_VFwritedata,
  input  logic              reg_WEVF,
  output logic [DATA_W-1:0] reg_readdata1,
  output logic [DATA_W-1:0] reg_readdata2,
  output logic [DATA_W-1:0] reg_VFreaddata,
  input  logic              bulk_start,
  input  logic              bulk_dir,
  input  nibble_t           bulk_last,
  output logic              bulk_busy,
  output logic              bulk_done,
  output logic              mem_req,
  output logic              mem_we,
  output nibble_t           mem_off,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [DATA_W-1:0] r_vreg [NREG];
  logic              w_busy;
  logic              w_we;
  logic              w_load_we;
  nibble_t           w_idx;

  chip8_bulk_seq u_seq (
    .cpu_clk   (cpu_clk),
    .reset_n   (reset_n),
    .i_start   (bulk_start),
    .i_dir     (bulk_dir),
    .i_last    (bulk_last),
    .i_ack     (mem_ack),
    .o_busy    (w_busy),
    .o_done    (bulk_done),
    .o_req     (mem_req),
    .o_we      (w_we),
    .o_idx     (w_idx),
    .o_load_we (w_load_we)
  );

  // Register storage; later assignments win, giving VF > port 1 > port 2.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREG; k++) begin
        r_vreg[k] <= '0;
      end
    end else if (w_load_we) begin
      r_vreg[w_idx] <= mem_rdata;
    end else if (!w_busy) begin
      if (reg_WE2) begin
        r_vreg[reg_addr2] <= reg_writedata2;
      end
      if (reg_WE1) begin
        r_vreg[reg_addr1] <= reg_writedata1;
      end
      if (reg_WEVF) begin
        r_vreg[VF_IDX] <= reg_VFwritedata;
      end
    end
  end

  // Store data is driven only during store beats so idle/reset shows zero.
  always_comb begin
    if (w_we) begin
      mem_wdata = r_vreg[w_idx];
    end else begin
      mem_wdata = '0;
    end
  end

  assign reg_readdata1  = r_vreg[reg_addr1];
  assign reg_readdata2  = r_vreg[reg_addr2];
  assign reg_VFreaddata = r_vreg[VF_IDX];
  assign bulk_busy      = w_busy;
  assign mem_we         = w_we;
  assign mem_off        = w_idx;

endmodule

// File: tb/tb_chip8_regfile_bank.sv
// Directed self-checking bench for chip8_regfile_bank: port writes and
// priorities, bulk store/load handshakes, and reset during a transfer.
module tb_chip8_regfile_bank;

  logic       cpu_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] reg_addr1 = 4'd0, reg_addr2 = 4'd0;
  logic [7:0] reg_writedata1 = 8'd0, reg_writedata2 = 8'd0;
  logic       reg_WE1 = 1'b0, reg_WE2 = 1'b0;
  logic [7:0] reg_VFwritedata = 8'd0;
  logic       reg_WEVF = 1'b0;
  logic [7:0] reg_readdata1, reg_readdata2, reg_VFreaddata;
  logic       bulk_start = 1'b0, bulk_dir = 1'b0;
  logic [3:0] bulk_last = 4'd0;
  logic       bulk_busy, bulk_done;
  logic       mem_req, mem_we;
  logic [3:0] mem_off;
  logic [7:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'd0;

  int checks = 0;
  int errors = 0;
  logic [7:0] store_exp [3];

  chip8_regfile_bank dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n),
    .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
    .reg_writedata1(reg_writedata1), .reg_writedata2(reg_writedata2),
    .reg_WE1(reg_WE1), .reg_WE2(reg_WE2),
    .reg_VFwritedata(reg_VFwritedata), .reg_WEVF(reg_WEVF),
    .reg_readdata1(reg_readdata1), .reg_readdata2(reg_readdata2),
    .reg_VFreaddata(reg_VFreaddata),
    .bulk_start(bulk_start), .bulk_dir(bulk_dir), .bulk_last(bulk_last),
    .bulk_busy(bulk_busy), .bulk_done(bulk_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_off(mem_off), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge cpu_clk);
  endtask

  initial begin
    store_exp[0] = 8'h10; store_exp[1] = 8'h20; store_exp[2] = 8'h30;

    // Reset state
    #2;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_busy", bulk_busy, 1'b0);
    chk("rst_done", bulk_done, 1'b0);
    chk("rst_off", mem_off, 4'd0);
    chk("rst_wdata", mem_wdata, 8'd0);
    chk("rst_vf", reg_VFreaddata, 8'd0);
    nclk(); reset_n = 1'b1;
    nclk();

    // Port-1 write V3=0x2A: old value during write cycle, new value after
    reg_addr1 = 4'd3; reg_writedata1 = 8'h2A; reg_WE1 = 1'b1; reg_addr2 = 4'd3;
    #1 chk("v3_old", reg_readdata2, 8'h00);
    nclk(); reg_WE1 = 1'b0;
    #1 chk("v3_new", reg_readdata2, 8'h2A);

    // Same-address conflict: port 1 wins
    nclk();
    reg_addr1 = 4'd5; reg_writedata1 = 8'h11; reg_WE1 = 1'b1;
    reg_addr2 = 4'd5; reg_writedata2 = 8'h22; reg_WE2 = 1'b1;
    nclk();
    #1 chk("v5_p1_wins", reg_readdata1, 8'h11);
    // Distinct addresses: both ports write
    reg_addr1 = 4'd7; reg_writedata1 = 8'h77; reg_addr2 = 4'd6; reg_writedata2 = 8'h66;
    nclk();
    #1 chk("v7_p1", reg_readdata1, 8'h77);
    chk("v6_p2", reg_readdata2, 8'h66);
    // VF port beats ports 1 and 2 at address F
    reg_addr1 = 4'hF; reg_writedata1 = 8'h01; reg_addr2 = 4'hF; reg_writedata2 = 8'h33;
    reg_VFwritedata = 8'h80; reg_WEVF = 1'b1;
    nclk();
    #1 chk("vf_port_wins", reg_VFreaddata, 8'h80);
    reg_WE1 = 1'b0; reg_WE2 = 1'b0; reg_WEVF = 1'b0;

    // Preload V0..V2 for the store
    reg_addr1 = 4'd0; reg_writedata1 = 8'h10; reg_WE1 = 1'b1;
    reg_addr2 = 4'd1; reg_writedata2 = 8'h20; reg_WE2 = 1'b1;
    nclk();
    reg_addr1 = 4'd2; reg_writedata1 = 8'h30; reg_WE2 = 1'b0;
    nclk();
    reg_WE1 = 1'b0;

    // Store V0..V2, ack every other cycle; a stray start mid-transfer is ignored
    bulk_start = 1'b1; bulk_dir = 1'b0; bulk_last = 4'd2;
    nclk(); bulk_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_ack = 1'b0;
      if (b == 1) begin
        bulk_start = 1'b1; bulk_dir = 1'b1; bulk_last = 4'hF;
      end
      #1;
      chk($sformatf("st_req_%0d", b), mem_req, 1'b1);
      chk($sformatf("st_we_%0d", b), mem_we, 1'b1);
      chk($sformatf("st_off_%0d", b), mem_off, b[3:0]);
      chk($sformatf("st_wdata_%0d", b), mem_wdata, store_exp[b]);
      chk($sformatf("st_busy_%0d", b), bulk_busy, 1'b1);
      nclk(); bulk_start = 1'b0; mem_ack = 1'b1;
      #1 chk($sformatf("st_hold_off_%0d", b), mem_off, b[3:0]);
      chk($sformatf("st_hold_wdata_%0d", b), mem_wdata, store_exp[b]);
      nclk();
    end
    mem_ack = 1'b0;
    #1 chk("st_done", bulk_done, 1'b1);
    chk("st_done_req", mem_req, 1'b0);
    chk("st_done_busy", bulk_busy, 1'b1);
    nclk();
    #1 chk("st_done_clr", bulk_done, 1'b0);
    chk("st_idle_busy", bulk_busy, 1'b0);

    // mem_ack in IDLE: no beats, no register change
    mem_ack = 1'b1; mem_rdata = 8'hEE; reg_addr1 = 4'd0;
    nclk(); nclk();
    #1 chk("idle_ack_req", mem_req, 1'b0);
    chk("idle_ack_busy", bulk_busy, 1'b0);
    chk("idle_ack_v0", reg_readdata1, 8'h10);
    mem_ack = 1'b0;

    // Load V0..VF with 0xF0+off, ack every cycle; CPU writes during busy ignored
    nclk();
    bulk_start = 1'b1; bulk_dir = 1'b1; bulk_last = 4'hF;
    nclk(); bulk_start = 1'b0;
    reg_addr1 = 4'd0; reg_writedata1 = 8'h55; reg_WE1 = 1'b1;
    reg_VFwritedata = 8'h99; reg_WEVF = 1'b1;
    for (int b = 0; b < 16; b++) begin
      #1;
      chk($sformatf("ld_req_%0d", b), mem_req, 1'b1);
      chk($sformatf("ld_we_%0d", b), mem_we, 1'b0);
      chk($sformatf("ld_off_%0d", b), mem_off, b[3:0]);
      mem_ack = 1'b1; mem_rdata = 8'hF0 + b[7:0];
      nclk();
    end
    mem_ack = 1'b0;
    #1 chk("ld_done", bulk_done, 1'b1);
    chk("ld_done_req", mem_req, 1'b0);
    nclk();
    reg_WE1 = 1'b0; reg_WEVF = 1'b0;
    #1 chk("ld_done_clr", bulk_done, 1'b0);
    for (int k = 0; k < 16; k++) begin
      reg_addr1 = k[3:0];
      #1 chk($sformatf("ld_v%0d", k), reg_readdata1, 8'hF0 + k[7:0]);
    end

    // Reset on beat 2 of a load with last=7
    nclk();
    bulk_start = 1'b1; bulk_dir = 1'b1; bulk_last = 4'd7;
    nclk(); bulk_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_ack = 1'b1; mem_rdata = 8'hA0 + b[7:0];
      nclk();
    end
    mem_ack = 1'b0;
    #1 chk("ab_off_beat2", mem_off, 4'd2);
    reset_n = 1'b0;
    #1 chk("ab_req", mem_req, 1'b0);
    chk("ab_busy", bulk_busy, 1'b0);
    chk("ab_done", bulk_done, 1'b0);
    chk("ab_off", mem_off, 4'd0);
    reg_addr1 = 4'd0; reg_addr2 = 4'd1;
    #1 chk("ab_v0", reg_readdata1, 8'h00);
    chk("ab_v1", reg_readdata2, 8'h00);
    chk("ab_vf", reg_VFreaddata, 8'h00);
    nclk(); reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mem_ack = 1'b1;
      nclk();
      #1 chk($sformatf("ab_post_done_%0d", c), bulk_done, 1'b0);
      chk($sformatf("ab_post_req_%0d", c), mem_req, 1'b0);
    end
    mem_ack = 1'b0;
    chk("ab_post_v0", reg_readdata1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
